key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CNT, default 25_000_000, hold time in Clk cycles for a long press (500 ms at 50 MHz).
REQ-002 SHALL have parameter DCLICK_CNT, default 12_500_000, maximum release-to-second-press gap in Clk cycles for a double click.
REQ-003 SHALL have parameter REPEAT_CNT, default 5_000_000, auto-repeat period in Clk cycles while a long press is held.
REQ-004 SHALL have port Clk, input, 1, system clock; all logic rising-edge.
REQ-005 SHALL have port Reset_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port key_flag, input, 1, single-cycle debounced-edge pulse from the key filter; pulses alternate press, release, press, ...
REQ-007 SHALL have port key_down, output, 1, level, high between a decoded press and its release.
REQ-008 SHALL have port short_press, output, 1, single-cycle pulse, one short click decoded.
REQ-009 SHALL have port long_press, output, 1, single-cycle pulse, hold reached LONG_CNT.
REQ-010 SHALL have port double_click, output, 1, single-cycle pulse, two clicks within DCLICK_CNT.
REQ-011 SHALL have port repeat_pulse, output, 1, single-cycle pulse every REPEAT_CNT cycles during a long hold.

Function
REQ-012 SHALL implement states IDLE, PRESSED, WAIT_SECOND, SECOND_PRESSED, LONG_HELD, with a single shared counter cnt of 25 bits.
REQ-013 SHALL, in IDLE on key_flag: go to PRESSED, cnt<=0, key_down<=1.
REQ-014 SHALL, in PRESSED on key_flag: go to WAIT_SECOND, cnt<=0, key_down<=0.
REQ-015 SHALL, in PRESSED without key_flag and cnt==LONG_CNT-1: pulse long_press, go to LONG_HELD, cnt<=0; otherwise cnt<=cnt+1.
REQ-016 SHALL, in LONG_HELD on key_flag: go to IDLE, cnt<=0, key_down<=0, no event pulse.
REQ-017 SHALL, in LONG_HELD without key_flag and cnt==REPEAT_CNT-1: pulse repeat_pulse, cnt<=0; otherwise cnt<=cnt+1.
REQ-018 SHALL, in WAIT_SECOND on key_flag: go to SECOND_PRESSED, key_down<=1.
REQ-019 SHALL, in WAIT_SECOND without key_flag and cnt==DCLICK_CNT-1: pulse short_press, go to IDLE, cnt<=0; otherwise cnt<=cnt+1.
REQ-020 SHALL, in SECOND_PRESSED on key_flag: pulse double_click, go to IDLE, key_down<=0; no timeout in this state.
REQ-021 SHALL give key_flag priority over any timeout in the same cycle.
REQ-022 SHALL register all outputs; each event pulse is high for exactly one cycle, beginning after the edge on which its condition is sampled.
REQ-023 SHALL never assert more than one of short_press, long_press, double_click, repeat_pulse in the same cycle.
REQ-024 SHALL hold cnt at 0 in IDLE and SECOND_PRESSED; cnt never exceeds max(LONG_CNT, DCLICK_CNT, REPEAT_CNT)-1.
REQ-025 SHALL treat a key_flag held high for several cycles as one event per sampled cycle; no pulse-width filtering.

Reset
REQ-026 SHALL, while Reset_n is low: state=IDLE, cnt=0, key_down=0, all event pulses 0.
REQ-027 SHALL, on reset mid-sequence, abandon any partial press or click without emitting an event; the first key_flag after release is decoded as a press.

Verification (LONG_CNT=20, DCLICK_CNT=10, REPEAT_CNT=5)
REQ-028 SHALL cover short click: press flag at edge P, release flag at P+5 -> key_down high P..P+5; short_press one cycle, registered at edge P+15; no other events.
REQ-029 SHALL cover double click: flags at P, P+4, P+8, P+12 -> one double_click registered at P+12; no short_press.
REQ-030 SHALL cover long hold with repeat: press at P, release at P+32 -> long_press at P+20; repeat_pulse at P+25 and P+30; none after P+32; key_down low after P+32.
REQ-031 SHALL cover simultaneity: release flag at P+5, second press exactly at P+15 -> SECOND_PRESSED, no short_press; release at P+18 -> double_click.
REQ-032 SHALL cover boundary: press at P, release at P+19 -> no long_press; short_press at P+29.
REQ-033 SHALL cover reset mid-hold: press at P, Reset_n low at P+10 for 3 cycles -> all outputs 0, no long_press; next flag starts a new press.

Source files
------------

// File: rtl/key_event_decoder.sv
// Key gesture decoder: turns debounced press/release flags into short, long,
// double-click and auto-repeat events using one shared 25-bit timer.
module key_event_decoder #(
   parameter int unsigned LONG_CNT   = 25_000_000,
   parameter int unsigned DCLICK_CNT = 12_500_000,
   parameter int unsigned REPEAT_CNT = 5_000_000
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic key_flag,
   output logic key_down,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic repeat_pulse
);

   localparam logic [24:0] LONG_MAX   = 25'(LONG_CNT - 1);
   localparam logic [24:0] DCLICK_MAX = 25'(DCLICK_CNT - 1);
   localparam logic [24:0] REPEAT_MAX = 25'(REPEAT_CNT - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      WAIT_SECOND,
      SECOND_PRESSED,
      LONG_HELD
   } state_t;

   state_t      state, state_nx;
   logic [24:0] cnt, cnt_nx;
   logic        key_down_nx, short_nx, long_nx, double_nx, repeat_nx;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         key_down     <= 1'b0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         double_click <= 1'b0;
         repeat_pulse <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         key_down     <= key_down_nx;
         short_press  <= short_nx;
         long_press   <= long_nx;
         double_click <= double_nx;
         repeat_pulse <= repeat_nx;
      end
   end

   // NOTE: every combinational output is given a default before the case so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      key_down_nx = key_down;
      short_nx    = 1'b0;
      long_nx     = 1'b0;
      double_nx   = 1'b0;
      repeat_nx   = 1'b0;

      // key_flag is tested first in each state so it wins over a timeout.
      unique case (state)
         IDLE: begin
            cnt_nx = '0;
            if (key_flag) begin
               state_nx    = PRESSED;
               key_down_nx = 1'b1;
            end
         end
         PRESSED: begin
            if (key_flag) begin
               state_nx    = WAIT_SECOND;
               cnt_nx      = '0;
               key_down_nx = 1'b0;
            end else if (cnt == LONG_MAX) begin
               state_nx = LONG_HELD;
               cnt_nx   = '0;
               long_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + 25'd1;
            end
         end
         LONG_HELD: begin
            if (key_flag) begin
               state_nx    = IDLE;
               cnt_nx      = '0;
               key_down_nx = 1'b0;
            end else if (cnt == REPEAT_MAX) begin
               cnt_nx    = '0;
               repeat_nx = 1'b1;
            end else begin
               cnt_nx = cnt + 25'd1;
            end
         end
         WAIT_SECOND: begin
            if (key_flag) begin
               state_nx    = SECOND_PRESSED;
               cnt_nx      = '0;
               key_down_nx = 1'b1;
            end else if (cnt == DCLICK_MAX) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               short_nx = 1'b1;
            end else begin
               cnt_nx = cnt + 25'd1;
            end
         end
         SECOND_PRESSED: begin
            cnt_nx = '0;
            if (key_flag) begin
               state_nx    = IDLE;
               key_down_nx = 1'b0;
               double_nx   = 1'b1;
            end
         end
         default: begin
            state_nx    = IDLE;
            cnt_nx      = '0;
            key_down_nx = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short timing parameters; each
// scenario steps edge by edge and compares outputs against hand-derived values.
module tb_key_event_decoder;

   localparam logic [3:0] EV_NONE  = 4'b0000;
   localparam logic [3:0] EV_SHORT = 4'b1000;
   localparam logic [3:0] EV_LONG  = 4'b0100;
   localparam logic [3:0] EV_DBL   = 4'b0010;
   localparam logic [3:0] EV_REP   = 4'b0001;

   logic Clk = 1'b0;
   logic Reset_n;
   logic key_flag;
   logic key_down, short_press, long_press, double_click, repeat_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   key_event_decoder #(
      .LONG_CNT  (20),
      .DCLICK_CNT(10),
      .REPEAT_CNT(5)
   ) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .key_flag    (key_flag),
      .key_down    (key_down),
      .short_press (short_press),
      .long_press  (long_press),
      .double_click(double_click),
      .repeat_pulse(repeat_pulse)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [3:0] events();
      return {short_press, long_press, double_click, repeat_pulse};
   endfunction

   // Present flag for the next rising edge, then inspect outputs 1 ns after it.
   task automatic step(input string tag, input int t, input logic flag,
                       input logic [3:0] exp_ev, input logic exp_kd);
      key_flag = flag;
      @(posedge Clk);
      #1;
      key_flag = 1'b0;
      check($sformatf("%s ev t=%0d", tag, t), {4'b0, events()}, {4'b0, exp_ev});
      check($sformatf("%s kd t=%0d", tag, t), {7'b0, key_down}, {7'b0, exp_kd});
   endtask

   initial begin
      Reset_n  = 1'b0;
      key_flag = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check("reset ev", {4'b0, events()}, 8'h00);
      check("reset kd", {7'b0, key_down}, 8'h00);
      Reset_n = 1'b1;
      repeat (2) step("idle", 0, 1'b0, EV_NONE, 1'b0);

      // Short click: press at 0, release at 5, timeout fires at 15.
      for (int t = 0; t <= 20; t++)
         step("short", t, (t == 0 || t == 5), (t == 15) ? EV_SHORT : EV_NONE, t < 5);

      // Double click: flags at 0,4,8,12.
      for (int t = 0; t <= 25; t++)
         step("dbl", t, (t == 0 || t == 4 || t == 8 || t == 12),
              (t == 12) ? EV_DBL : EV_NONE, (t < 4) || (t >= 8 && t < 12));

      // Long hold with repeat: press at 0, release at 32.
      for (int t = 0; t <= 40; t++)
         step("long", t, (t == 0 || t == 32),
              (t == 20) ? EV_LONG : ((t == 25 || t == 30) ? EV_REP : EV_NONE), t < 32);

      // Second press on the same edge the click timeout would fire.
      for (int t = 0; t <= 30; t++)
         step("simul", t, (t == 0 || t == 5 || t == 15 || t == 18),
              (t == 18) ? EV_DBL : EV_NONE, (t < 5) || (t >= 15 && t < 18));

      // Release one edge before the long threshold.
      for (int t = 0; t <= 35; t++)
         step("bound", t, (t == 0 || t == 19), (t == 29) ? EV_SHORT : EV_NONE, t < 19);

      // Reset in the middle of a hold abandons it silently.
      for (int t = 0; t < 10; t++)
         step("rsthold", t, (t == 0), EV_NONE, 1'b1);
      Reset_n = 1'b0;
      #1;
      check("rst async ev", {4'b0, events()}, 8'h00);
      check("rst async kd", {7'b0, key_down}, 8'h00);
      for (int t = 0; t < 3; t++)
         step("rstlow", t, 1'b0, EV_NONE, 1'b0);
      Reset_n = 1'b1;
      for (int t = 0; t <= 25; t++)
         step("postrst", t, 1'b0, EV_NONE, 1'b0);
      for (int t = 0; t <= 20; t++)
         step("newpress", t, (t == 0 || t == 5), (t == 15) ? EV_SHORT : EV_NONE, t < 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
